// File: rtl/exc_pkg.sv
// Shared definitions for the exception/interrupt controller: FSM states,
// cause codes and the channel-count bound.
package exc_pkg;

   localparam int NIRQ_MAX = 8;
   localparam int IDX_W    = $clog2(NIRQ_MAX);

   localparam logic [3:0] CAUSE_IRQ_BASE = 4'b1000;
   localparam logic [3:0] CAUSE_NESTED   = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_SERVE = 2'd2
   } exc_state_e;

endpackage

// File: rtl/prio_enc.sv
// Lowest-index-wins priority encoder over the eligible interrupt channels.
module prio_enc
   import exc_pkg::*;
#(
   parameter int NIRQ = 4
) (
   input  logic [NIRQ-1:0]  req_i,
   output logic             valid_o,
   output logic [IDX_W-1:0] idx_o
);

   // Scan from the top so the lowest set bit is the last one written.
   always_comb begin
      valid_o = |req_i;
      idx_o   = '0;
      for (int k = NIRQ - 1; k >= 0; k--) begin
         if (req_i[k]) begin
            idx_o = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/exc_irq_ctrl.sv
// Exception/interrupt controller: edge-latched pending interrupts, enable mask,
// sync-exception priority and a three-state request/serve handshake.
module exc_irq_ctrl
   import exc_pkg::*;
#(
   parameter int              NIRQ     = 4,
   parameter logic [NIRQ-1:0] MASK_RST = {NIRQ{1'b1}}
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NIRQ-1:0] irq,
   output logic [NIRQ-1:0] irq_ack,
   input  logic            sync_exc,
   input  logic [3:0]      sync_code,
   input  logic            ExcAck,
   input  logic            ERet,
   input  logic            mask_we,
   input  logic [NIRQ-1:0] mask_wdata,
   output logic            Exc,
   output logic [3:0]      EStatus,
   output logic            busy
);

   logic [NIRQ-1:0]  irq_q, irq_prev_q, block_q, block_d;
   logic [NIRQ-1:0]  pend_q, pend_d, mask_q, mask_d;
   logic [NIRQ-1:0]  ack_q, ack_d, chan_onehot, rise;
   exc_state_e       state_q, state_d;
   logic [3:0]       estatus_q, estatus_d;
   logic [IDX_W-1:0] chan_q, chan_d, elig_idx;
   logic             sync_q, sync_d, exc_q, exc_d, elig_valid;

   prio_enc #(.NIRQ(NIRQ)) u_prio (
      .req_i   (pend_q & mask_q),
      .valid_o (elig_valid),
      .idx_o   (elig_idx)
   );

   // Lines high through reset stay blocked until they are seen low once.
   assign rise    = irq_q & ~irq_prev_q & ~block_q;
   assign block_d = block_q & irq;
   assign mask_d  = mask_we ? mask_wdata : mask_q;
   assign pend_d  = (pend_q & ~ack_d) | rise;

   always_comb begin
      chan_onehot = '0;
      for (int k = 0; k < NIRQ; k++) begin
         chan_onehot[k] = (chan_q == IDX_W'(k));
      end
   end

   // A sync exception in SERVE wins over a simultaneous ERet (nested fault).
   always_comb begin
      state_d   = state_q;
      estatus_d = estatus_q;
      chan_d    = chan_q;
      sync_d    = sync_q;
      ack_d     = '0;
      case (state_q)
         ST_IDLE: begin
            estatus_d = 4'b0000;
            if (sync_exc) begin
               state_d   = ST_REQ;
               estatus_d = sync_code;
               sync_d    = 1'b1;
            end else if (elig_valid) begin
               state_d   = ST_REQ;
               estatus_d = CAUSE_IRQ_BASE | {1'b0, elig_idx};
               chan_d    = elig_idx;
               sync_d    = 1'b0;
            end
         end
         ST_REQ: begin
            if (ExcAck) begin
               state_d = ST_SERVE;
               if (!sync_q) begin
                  ack_d = chan_onehot;
               end
            end
         end
         ST_SERVE: begin
            if (sync_exc) begin
               state_d   = ST_REQ;
               estatus_d = CAUSE_NESTED;
               sync_d    = 1'b1;
            end else if (ERet) begin
               state_d   = ST_IDLE;
               estatus_d = 4'b0000;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            estatus_d = 4'b0000;
         end
      endcase
   end

   assign exc_d = (state_d == ST_REQ);

   always_ff @(posedge clk) begin
      if (!reset) begin
         irq_q      <= '0;
         irq_prev_q <= '0;
         block_q    <= '1;
         pend_q     <= '0;
         mask_q     <= MASK_RST;
         ack_q      <= '0;
         state_q    <= ST_IDLE;
         estatus_q  <= 4'b0000;
         chan_q     <= '0;
         sync_q     <= 1'b0;
         exc_q      <= 1'b0;
      end else begin
         irq_q      <= irq;
         irq_prev_q <= irq_q;
         block_q    <= block_d;
         pend_q     <= pend_d;
         mask_q     <= mask_d;
         ack_q      <= ack_d;
         state_q    <= state_d;
         estatus_q  <= estatus_d;
         chan_q     <= chan_d;
         sync_q     <= sync_d;
         exc_q      <= exc_d;
      end
   end

   assign irq_ack = ack_q;
   assign Exc     = exc_q;
   assign EStatus = estatus_q;
   assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// Self-checking bench for exc_irq_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a model.
module tb_exc_irq_ctrl;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] irq;
   logic [3:0] irq_ack;
   logic       sync_exc;
   logic [3:0] sync_code;
   logic       ExcAck;
   logic       ERet;
   logic       mask_we;
   logic [3:0] mask_wdata;
   logic       Exc;
   logic [3:0] EStatus;
   logic       busy;

   int assertions = 0;
   int failures   = 0;

   exc_irq_ctrl #(.NIRQ(4), .MASK_RST(4'b1111)) dut (
      .clk        (clk),
      .reset      (reset),
      .irq        (irq),
      .irq_ack    (irq_ack),
      .sync_exc   (sync_exc),
      .sync_code  (sync_code),
      .ExcAck     (ExcAck),
      .ERet       (ERet),
      .mask_we    (mask_we),
      .mask_wdata (mask_wdata),
      .Exc        (Exc),
      .EStatus    (EStatus),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Reference model state: mode 0=idle, 1=requesting, 2=in handler
   int         mMode = 0;
   logic [3:0] mCause = 4'h0;
   logic [3:0] mPend = 4'h0;
   logic [3:0] mMask = 4'hF;
   logic [3:0] mAck = 4'h0;
   logic [3:0] mArmed = 4'h0;
   logic [3:0] mLast = 4'h0;
   logic [3:0] mRiseDly = 4'h0;
   logic       mSync = 1'b0;
   int         mChan = 0;
   logic       modelValid = 1'b0;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      assertions++;
      if (act !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic applyStimulus(input logic [3:0] irqV, input logic sExc, input logic [3:0] sCode,
                                input logic eAck, input logic eRet, input logic mWe,
                                input logic [3:0] mData);
      irq        = irqV;
      sync_exc   = sExc;
      sync_code  = sCode;
      ExcAck     = eAck;
      ERet       = eRet;
      mask_we    = mWe;
      mask_wdata = mData;
      @(negedge clk);
   endtask

   task automatic idleFor(input logic [3:0] irqV, input int n);
      for (int i = 0; i < n; i++) applyStimulus(irqV, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
   endtask

   task automatic ackOnce(input logic [3:0] irqV);
      applyStimulus(irqV, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);
   endtask

   task automatic eretOnce(input logic [3:0] irqV);
      applyStimulus(irqV, 1'b0, 4'h0, 1'b0, 1'b1, 1'b0, 4'h0);
   endtask

   // Behavioural model: pending is set one edge after a rising sample of an
   // armed line; the handshake is advanced from the pre-edge pending/mask.
   always @(posedge clk) begin : model
      logic [3:0] elig;
      logic [3:0] ackNew;
      int         low;
      if (!reset) begin
         mMode = 0; mCause = 4'h0; mPend = 4'h0; mMask = 4'hF; mAck = 4'h0;
         mArmed = 4'h0; mLast = 4'h0; mRiseDly = 4'h0; mSync = 1'b0; mChan = 0;
         modelValid = 1'b1;
      end else begin
         elig   = mPend & mMask;
         ackNew = 4'h0;
         if (mMode == 0) begin
            mCause = 4'h0;
            if (sync_exc) begin
               mMode = 1; mCause = sync_code; mSync = 1'b1;
            end else if (elig != 4'h0) begin
               low = 0;
               for (int k = 3; k >= 0; k--) if (elig[k]) low = k;
               mMode = 1; mCause = 4'(8 + low); mChan = low; mSync = 1'b0;
            end
         end else if (mMode == 1) begin
            if (ExcAck) begin
               mMode = 2;
               if (!mSync) ackNew[mChan] = 1'b1;
            end
         end else begin
            if (sync_exc) begin
               mMode = 1; mCause = 4'hF; mSync = 1'b1;
            end else if (ERet) begin
               mMode = 0; mCause = 4'h0;
            end
         end
         mAck     = ackNew;
         mPend    = (mPend & ~ackNew) | mRiseDly;
         mRiseDly = irq & ~mLast & mArmed;
         mArmed   = mArmed | ~irq;
         mLast    = irq;
         if (mask_we) mMask = mask_wdata;
      end
   end

   always @(posedge clk) begin
      #1;
      if (modelValid) begin
         checkOutput("Exc", 32'(Exc), 32'(mMode == 1));
         checkOutput("EStatus", 32'(EStatus), 32'(mCause));
         checkOutput("irq_ack", 32'(irq_ack), 32'(mAck));
         checkOutput("busy", 32'(busy), 32'(mMode != 0));
         checkOutput("pend", 32'(dut.pend_q), 32'(mPend));
         checkOutput("mask", 32'(dut.mask_q), 32'(mMask));
      end
   end

   initial begin
      #400000;
      $display("[TB] FAIL timeout: simulation did not finish");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      logic [3:0] irqR;
      reset = 1'b0;
      irq = 4'h0; sync_exc = 1'b0; sync_code = 4'h0; ExcAck = 1'b0; ERet = 1'b0;
      mask_we = 1'b0; mask_wdata = 4'h0;
      @(negedge clk);
      idleFor(4'h0, 2);
      checkOutput("rst_Exc", 32'(Exc), 32'd0);
      checkOutput("rst_EStatus", 32'(EStatus), 32'd0);
      checkOutput("rst_irq_ack", 32'(irq_ack), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      reset = 1'b1;
      idleFor(4'h0, 2);

      $display("[TB] single interrupt on channel 2");
      idleFor(4'b0100, 2);
      checkOutput("A_Exc_early", 32'(Exc), 32'd0);
      checkOutput("A_pend2_set", 32'(dut.pend_q[2]), 32'd1);
      idleFor(4'b0100, 1);
      checkOutput("A_Exc", 32'(Exc), 32'd1);
      checkOutput("A_EStatus", 32'(EStatus), 32'hA);
      ackOnce(4'b0100);
      checkOutput("A_irq_ack", 32'(irq_ack), 32'h4);
      checkOutput("A_pend2_clr", 32'(dut.pend_q[2]), 32'd0);
      checkOutput("A_Exc_off", 32'(Exc), 32'd0);
      idleFor(4'b0100, 1);
      checkOutput("A_irq_ack_once", 32'(irq_ack), 32'h0);
      eretOnce(4'b0000);
      checkOutput("A_idle_busy", 32'(busy), 32'd0);
      checkOutput("A_idle_EStatus", 32'(EStatus), 32'd0);
      idleFor(4'h0, 2);

      $display("[TB] channels 1 and 3 together");
      idleFor(4'b1010, 3);
      checkOutput("B_EStatus1", 32'(EStatus), 32'h9);
      ackOnce(4'b1010);
      checkOutput("B_ack1", 32'(irq_ack), 32'h2);
      eretOnce(4'b1010);
      idleFor(4'b1010, 1);
      checkOutput("B_Exc3", 32'(Exc), 32'd1);
      checkOutput("B_EStatus3", 32'(EStatus), 32'hB);
      ackOnce(4'b1010);
      checkOutput("B_ack3", 32'(irq_ack), 32'h8);
      eretOnce(4'b0000);
      idleFor(4'h0, 2);

      $display("[TB] sync exception beats channel 0");
      applyStimulus(4'b0001, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 4'h0);
      checkOutput("C_EStatus_sync", 32'(EStatus), 32'h1);
      idleFor(4'b0001, 1);
      ackOnce(4'b0001);
      checkOutput("C_no_ack", 32'(irq_ack), 32'h0);
      eretOnce(4'b0001);
      idleFor(4'b0001, 1);
      checkOutput("C_EStatus_irq0", 32'(EStatus), 32'h8);
      ackOnce(4'b0001);
      checkOutput("C_ack0", 32'(irq_ack), 32'h1);
      eretOnce(4'b0000);
      idleFor(4'h0, 2);

      $display("[TB] masked channel 0");
      applyStimulus(4'b0000, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'b1110);
      idleFor(4'b0001, 5);
      checkOutput("D_masked_Exc", 32'(Exc), 32'd0);
      checkOutput("D_still_pend", 32'(dut.pend_q[0]), 32'd1);
      applyStimulus(4'b0001, 1'b0, 4'h0, 1'b0, 1'b0, 1'b1, 4'b1111);
      idleFor(4'b0001, 1);
      checkOutput("D_Exc", 32'(Exc), 32'd1);
      checkOutput("D_EStatus", 32'(EStatus), 32'h8);
      ackOnce(4'b0001);
      eretOnce(4'b0000);
      idleFor(4'h0, 2);

      $display("[TB] nested fault in handler");
      idleFor(4'b0010, 3);
      ackOnce(4'b0010);
      applyStimulus(4'b0010, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 4'h0);
      checkOutput("E_Exc", 32'(Exc), 32'd1);
      checkOutput("E_EStatus", 32'(EStatus), 32'hF);
      ackOnce(4'b0010);
      checkOutput("E_no_ack", 32'(irq_ack), 32'h0);
      eretOnce(4'b0000);
      idleFor(4'h0, 2);

      $display("[TB] reset while requesting");
      idleFor(4'b0100, 3);
      checkOutput("F_Exc_pre", 32'(Exc), 32'd1);
      reset = 1'b0;
      idleFor(4'b0100, 1);
      checkOutput("F_Exc_rst", 32'(Exc), 32'd0);
      checkOutput("F_pend_rst", 32'(dut.pend_q), 32'd0);
      checkOutput("F_ack_rst", 32'(irq_ack), 32'd0);
      reset = 1'b1;
      idleFor(4'b0100, 4);
      checkOutput("F_held_Exc", 32'(Exc), 32'd0);
      checkOutput("F_held_pend", 32'(dut.pend_q), 32'd0);
      idleFor(4'b0000, 1);
      idleFor(4'b0100, 3);
      checkOutput("F_rearm_EStatus", 32'(EStatus), 32'hA);
      ackOnce(4'b0100);
      eretOnce(4'b0000);
      idleFor(4'h0, 2);

      $display("[TB] randomized traffic");
      irqR = 4'h0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 7) == 0) irqR[2'($urandom_range(0, 3))] ^= 1'b1;
         reset = ($urandom_range(0, 249) != 0);
         applyStimulus(irqR, $urandom_range(0, 19) == 0, 4'($urandom_range(0, 15)),
                       $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0,
                       $urandom_range(0, 39) == 0, 4'($urandom_range(0, 15)));
      end
      reset = 1'b1;
      idleFor(4'h0, 2);

      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule

// File: doc/exc_irq_ctrl.md
EXC_IRQ_CTRL -- requirements
Module: exc_irq_ctrl

Interface
REQ-001 The module SHALL have parameter NIRQ, default 4, meaning the number of external interrupt channels (legal range 1..8).
REQ-002 The module SHALL have parameter MASK_RST, default all-ones, meaning the reset value of the NIRQ-bit interrupt enable mask.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 Port reset, input, 1 bit: synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 Port irq, input, NIRQ bits: level interrupt lines from devices, one per channel.
REQ-006 Port irq_ack, output, NIRQ bits: one-hot single-cycle acknowledge to the serviced channel.
REQ-007 Port sync_exc and sync_code, inputs, 1 and 4 bits: synchronous exception from the decoder, with its cause code.
REQ-008 Port ExcAck, input, 1 bit: the datapath has vectored to the handler.
REQ-009 Port ERet, input, 1 bit: an ERET instruction is retiring.
REQ-010 Port mask_we and mask_wdata, inputs, 1 and NIRQ bits: enable-mask write.
REQ-011 Port Exc, output, 1 bit: exception request to the datapath.
REQ-012 Port EStatus, output, 4 bits: cause of the current exception.
REQ-013 Port busy, output, 1 bit: high while the FSM is not IDLE.

Function
REQ-014 irq SHALL be registered once; pend[k] SHALL set on a 0->1 transition of the registered irq[k].
REQ-015 pend[k] SHALL clear in the cycle irq_ack[k] pulses; when a new edge coincides with that clear, set SHALL win.
REQ-016 eligible SHALL equal pend AND mask; mask_we SHALL update mask on the next edge, and masked channels SHALL stay pending.
REQ-017 Priority SHALL be: sync_exc first, then the lowest-index eligible channel.
REQ-018 FSM states SHALL be IDLE, REQ, SERVE.
REQ-019 IDLE->REQ: when sync_exc or any eligible bit is set, latch EStatus = sync_code (sync) or 4'b1000|k (IRQ k) and latch the channel index.
REQ-020 REQ: Exc SHALL be 1, EStatus stable; REQ->SERVE on ExcAck; Exc SHALL be 0 in every other state.
REQ-021 On the REQ->SERVE edge, irq_ack SHALL pulse for exactly one cycle for the latched channel, and stay zero for sync causes.
REQ-022 SERVE: EStatus held, new edges only set pend (no nesting); SERVE->IDLE on ERet.
REQ-023 sync_exc in SERVE SHALL go to REQ with EStatus=4'b1111 (nested fault); sync_exc in REQ SHALL be ignored.
REQ-024 ERet in IDLE or REQ SHALL be ignored; ExcAck outside REQ SHALL be ignored.
REQ-025 Latency: an irq rise sampled at edge t SHALL give Exc=1 after edge t+2 when in IDLE and unmasked.
REQ-026 In IDLE, EStatus SHALL read 4'b0000.

Reset
REQ-027 On reset=0 at a clock edge: state IDLE, pend=0, registered irq=0, mask=MASK_RST, Exc=0, EStatus=0, irq_ack=0, busy=0.
REQ-028 Reset mid-REQ or mid-SERVE SHALL abandon the exception with no irq_ack pulse; lines still high after reset SHALL not be pending until they fall and rise again.

Structure
REQ-029 The FSM state enum, the cause codes (4'b1000 IRQ base, 4'b1111 nested fault) and the NIRQ bound SHALL live in a shared package exc_pkg.
REQ-030 The lowest-index eligible selection SHALL be one sub-module, prio_enc, parameterised by NIRQ, that outputs a valid bit and an index.
REQ-031 All outputs SHALL be registered except busy, which SHALL decode from state.

Verification
REQ-032 The bench SHALL cover: irq=4'b0100 rise, ExcAck 3 cycles later -> Exc high 2 cycles after the sampled edge, EStatus=4'b1010, irq_ack=4'b0100 for one cycle, pend[2] cleared.
REQ-033 The bench SHALL cover: irq[1] and irq[3] rise together -> channel 1 served first (EStatus=4'b1001); after ERet, channel 3 served (EStatus=4'b1011).
REQ-034 The bench SHALL cover: sync_exc with sync_code=4'b0001 in the same cycle as an irq[0] edge -> EStatus=4'b0001, irq_ack stays 0, irq[0] served after ERet.
REQ-035 The bench SHALL cover: mask_wdata=4'b1110 written, then irq[0] rises -> no Exc; mask rewritten to 4'b1111 -> Exc with EStatus=4'b1000.
REQ-036 The bench SHALL cover: sync_exc while in SERVE -> REQ with EStatus=4'b1111.
REQ-037 The bench SHALL cover: reset=0 while in REQ -> Exc=0 and pend=0 on the next edge, with no irq_ack pulse.
